// File: rtl/traffic_pkg.sv
// Shared types for the intersection scheduler: light codes, phase states and
// a helper that places one approach's light code into the packed light vector.
package traffic_pkg;

   localparam int N_APPR = 4;

   typedef enum logic [1:0] {
      LIGHT_RED    = 2'd0,
      LIGHT_YELLOW = 2'd1,
      LIGHT_GREEN  = 2'd2
   } light_e;

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_ALLRED = 2'd2,
      PH_WALK   = 2'd3
   } phase_e;

   // Every approach other than idx is left at RED (code 0).
   function automatic logic [2*N_APPR-1:0] light_vec(input logic [1:0] idx, input light_e code);
      light_vec = (2*N_APPR)'(code) << {idx, 1'b0};
   endfunction

endpackage

// File: rtl/intersection_phase_arbiter_rr_pick.sv
// Combinational round-robin search: first requesting approach after i_owner,
// with i_owner itself checked last. o_grant is 0 when nothing requests.
module rr_pick
   import traffic_pkg::*;
(
   input  logic [N_APPR-1:0] i_req,
   input  logic [1:0]        i_owner,
   output logic [1:0]        o_grant,
   output logic              o_any_req
);

   logic [1:0] w_idx;

   always_comb begin
      o_grant   = 2'd0;
      o_any_req = |i_req;
      w_idx     = 2'd0;
      // Walk the order backwards so the earliest candidate is written last.
      for (int k = N_APPR; k >= 1; k--) begin
         w_idx = i_owner + 2'(k);
         if (i_req[w_idx]) o_grant = w_idx;
      end
   end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Four-approach GREEN/YELLOW/ALLRED phase scheduler with round-robin hand-over.
// Optional pedestrian WALK interval is built when PED_WALK_EN is defined.
module intersection_phase_arbiter
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN  = 4,
   parameter int GREEN_MAX  = 12,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int WALK_CYC   = 6,
   parameter int CNT_W      = 4
)(
   input  logic                clk,
   input  logic                clr,
   input  logic [N_APPR-1:0]   req,
`ifdef PED_WALK_EN
   input  logic                ped_req,
   output logic                walk,
`endif
   output logic [2*N_APPR-1:0] light,
   output logic [1:0]          owner,
   output logic                busy,
   output logic [1:0]          o_dbg_state
);

   localparam logic [CNT_W-1:0] L_GMIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] L_GMAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] L_Y_LAST    = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] L_AR_LAST   = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] L_W_LAST    = CNT_W'(WALK_CYC - 1);

   phase_e              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [1:0]          r_owner;
   logic [2*N_APPR-1:0] r_light;
   logic                r_busy;
`ifdef PED_WALK_EN
   logic                r_ped;
   logic                r_walk;
`endif

   logic [N_APPR-1:0]   w_owner_mask;
   logic                w_other;
   logic                w_exit;
   logic [CNT_W-1:0]    w_cnt_inc;
   logic [1:0]          w_grant;
   logic                w_any_req;
   logic [1:0]          w_next_owner;

   rr_pick u_rr_pick (
      .i_req     (req),
      .i_owner   (r_owner),
      .o_grant   (w_grant),
      .o_any_req (w_any_req)
   );

   always_comb begin
      w_owner_mask = 4'b0001 << r_owner;
`ifdef PED_WALK_EN
      w_other = (|(req & ~w_owner_mask)) | r_ped;
`else
      w_other = |(req & ~w_owner_mask);
`endif
      w_exit = w_other &&
               (((r_cnt >= L_GMIN_LAST) && !req[r_owner]) || (r_cnt >= L_GMAX_LAST));
      w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
      w_next_owner = w_any_req ? w_grant : 2'd0;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= PH_ALLRED;
         r_cnt   <= '0;
         r_owner <= 2'd0;
         r_light <= '0;
         r_busy  <= 1'b1;
`ifdef PED_WALK_EN
         r_ped   <= 1'b0;
         r_walk  <= 1'b0;
`endif
      end else begin
`ifdef PED_WALK_EN
         if (ped_req) r_ped <= 1'b1;
`endif
         case (r_state)
            PH_GREEN: begin
               if (w_exit) begin
                  r_state <= PH_YELLOW;
                  r_cnt   <= '0;
                  r_light <= light_vec(r_owner, LIGHT_YELLOW);
                  r_busy  <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            PH_YELLOW: begin
               if (r_cnt == L_Y_LAST) begin
                  r_cnt   <= '0;
                  r_light <= '0;
                  r_busy  <= 1'b1;
`ifdef PED_WALK_EN
                  // Clearing the latch here wins over a ped_req arriving on this edge.
                  if (r_ped) begin
                     r_state <= PH_WALK;
                     r_walk  <= 1'b1;
                     r_ped   <= 1'b0;
                  end else begin
                     r_state <= PH_ALLRED;
                  end
`else
                  r_state <= PH_ALLRED;
`endif
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            PH_WALK: begin
               if (r_cnt == L_W_LAST) begin
                  r_state <= PH_ALLRED;
                  r_cnt   <= '0;
`ifdef PED_WALK_EN
                  r_walk  <= 1'b0;
`endif
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            PH_ALLRED: begin
               if (r_cnt == L_AR_LAST) begin
                  r_state <= PH_GREEN;
                  r_cnt   <= '0;
                  r_owner <= w_next_owner;
                  r_light <= light_vec(w_next_owner, LIGHT_GREEN);
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= PH_ALLRED;
               r_cnt   <= '0;
               r_light <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   assign light       = r_light;
   assign owner       = r_owner;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;
`ifdef PED_WALK_EN
   assign walk        = r_walk;
`endif

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Scoreboard bench for intersection_phase_arbiter: each expected cycle of
// {walk, busy, owner, light} is queued with the stimulus and popped per edge.
module tb_intersection_phase_arbiter;
   import traffic_pkg::*;

   localparam int W = 12;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [7:0] light;
   logic [1:0] owner;
   logic       busy;
   logic [1:0] dbg_state;
   logic       walk_w;
`ifdef PED_WALK_EN
   logic       ped_req = 1'b0;
   logic       walk;
   assign walk_w = walk;
`else
   assign walk_w = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   intersection_phase_arbiter dut (
      .clk         (clk),
      .clr         (clr),
      .req         (req),
`ifdef PED_WALK_EN
      .ped_req     (ped_req),
      .walk        (walk),
`endif
      .light       (light),
      .owner       (owner),
      .busy        (busy),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] lt(input int idx, input logic [1:0] code);
      lt = 8'(code) << (2 * idx);
   endfunction

   function automatic logic [W-1:0] word(input logic [7:0] l, input int o, input logic b, input logic w);
      word = {w, b, 2'(o), l};
   endfunction

   task automatic push_n(input logic [W-1:0] v, input int n);
      repeat (n) exp_q.push_back(v);
   endtask

   // Green entry of owner o is already observed; queue the rest of its green,
   // yellow, all-red and the green entry of the next owner.
   task automatic push_handover(input int o, input int n_green, input int nxt);
      push_n(word(lt(o, 2'd2), o, 1'b0, 1'b0), n_green - 1);
      push_n(word(lt(o, 2'd1), o, 1'b1, 1'b0), 3);
      push_n(word(8'h00, o, 1'b1, 1'b0), 2);
      push_n(word(lt(nxt, 2'd2), nxt, 1'b0, 1'b0), 1);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      logic [W-1:0] e;
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check_val(tag, {4'b0, walk_w, busy, owner, light}, {4'b0, e});
      end
   endtask

   task automatic do_reset;
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      // reset state, then home approach takes green with no requests
      clr = 1'b1;
      tick();
      check_val("rst_light", {8'h0, light}, 16'h0000);
      check_val("rst_owner", {14'h0, owner}, 16'h0000);
      check_val("rst_busy", {15'h0, busy}, 16'h0001);
      check_val("rst_state", {14'h0, dbg_state}, 16'(PH_ALLRED));
      clr = 1'b0;
      push_n(word(8'h00, 0, 1'b1, 1'b0), 1);
      push_n(word(8'h02, 0, 1'b0, 1'b0), 23);
      drain("home_hold");
      check_val("green_state", {14'h0, dbg_state}, 16'(PH_GREEN));

      // gap-out from approach 0 to approach 2
      do_reset();
      push_n(word(8'h00, 0, 1'b1, 1'b0), 1);
      push_n(word(8'h02, 0, 1'b0, 1'b0), 1);
      drain("gap_setup");
      req = 4'b0100;
      push_handover(0, 4, 2);
      drain("gapout");
      check_val("gap_light", {8'h0, light}, 16'h0020);
      push_n(word(8'h20, 2, 1'b0, 1'b0), 5);
      drain("hold2");

      // max-out 0 -> 1 -> 0 with both requesting
      req = 4'b0000;
      do_reset();
      push_n(word(8'h00, 0, 1'b1, 1'b0), 1);
      push_n(word(8'h02, 0, 1'b0, 1'b0), 1);
      drain("max_setup");
      req = 4'b0011;
      push_handover(0, 12, 1);
      push_handover(1, 12, 0);
      drain("maxout");

      // gap-out to 1, then round-robin 2, 3, wrap to 1
      req = 4'b0010;
      push_handover(0, 4, 1);
      drain("rr_setup");
      req = 4'b1110;
      push_handover(1, 12, 2);
      push_handover(2, 12, 3);
      push_handover(3, 12, 1);
      drain("rr_wrap");

      // clr in the middle of yellow aborts straight to reset values
      push_n(word(lt(1, 2'd2), 1, 1'b0, 1'b0), 11);
      push_n(word(lt(1, 2'd1), 1, 1'b1, 1'b0), 1);
      drain("pre_clr");
      check_val("yellow_state", {14'h0, dbg_state}, 16'(PH_YELLOW));
      clr = 1'b1;
      req = 4'b0000;
      tick();
      check_val("clr_light", {8'h0, light}, 16'h0000);
      check_val("clr_owner", {14'h0, owner}, 16'h0000);
      check_val("clr_busy", {15'h0, busy}, 16'h0001);
      check_val("clr_state", {14'h0, dbg_state}, 16'(PH_ALLRED));
      clr = 1'b0;
      push_n(word(8'h00, 0, 1'b1, 1'b0), 1);
      push_n(word(8'h02, 0, 1'b0, 1'b0), 3);
      drain("clr_restart");

`ifdef PED_WALK_EN
      // one-cycle pedestrian pulse forces a WALK interval after yellow
      do_reset();
      push_n(word(8'h00, 0, 1'b1, 1'b0), 1);
      push_n(word(8'h02, 0, 1'b0, 1'b0), 1);
      drain("ped_setup");
      ped_req = 1'b1;
      push_n(word(8'h02, 0, 1'b0, 1'b0), 1);
      drain("ped_pulse");
      ped_req = 1'b0;
      push_n(word(8'h02, 0, 1'b0, 1'b0), 2);
      push_n(word(8'h01, 0, 1'b1, 1'b0), 3);
      push_n(word(8'h00, 0, 1'b1, 1'b1), 6);
      push_n(word(8'h00, 0, 1'b1, 1'b0), 2);
      push_n(word(8'h02, 0, 1'b0, 1'b0), 8);
      drain("ped_walk");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
